// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the 8-bit DataMemory.
// Port 0 is the CPU load/store unit, port 1 is the I/O/DMA engine. One access
// is in flight at a time: IDLE -> ISSUE -> (WAIT x RD_LAT) -> RESP -> IDLE.
module data_memory_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req,
   input  logic                  p0_write,
   input  logic [ADDR_WIDTH-1:0] p0_address,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_ack,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_write,
   input  logic [ADDR_WIDTH-1:0] p1_address,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_ack,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_data_inputs,
   input  logic [DATA_WIDTH-1:0] mem_data_outputs,
   output logic                  busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   // WAIT counts down to zero; the capture happens on the cycle the count is zero.
   localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   logic [1:0] state_reg;
   logic [1:0] wait_cnt_reg;
   logic       last_grant_reg;
   logic       cmd_port_reg;
   logic       cmd_write_reg;

   logic       grant_valid;
   logic       grant_port;
   logic       capture_en;

   // Round-robin choice: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      grant_valid = p0_req | p1_req;
      if (p0_req && p1_req) begin
         grant_port = ~last_grant_reg;
      end else begin
         grant_port = p1_req;
      end
   end

   // Read data is sampled at the end of ISSUE (zero latency) or of the last WAIT cycle.
   always_comb begin
      capture_en = 1'b0;
      if (state_reg == ISSUE && !cmd_write_reg && RD_LAT == 0) begin
         capture_en = 1'b1;
      end else if (state_reg == WAIT && wait_cnt_reg == 2'd0) begin
         capture_en = 1'b1;
      end
   end

   // Sequencer: latches the winning command and steps through the access phases.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         wait_cnt_reg    <= 2'd0;
         last_grant_reg  <= 1'b1;
         cmd_port_reg    <= 1'b0;
         cmd_write_reg   <= 1'b0;
         mem_address     <= '0;
         mem_data_inputs <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  cmd_port_reg    <= grant_port;
                  last_grant_reg  <= grant_port;
                  cmd_write_reg   <= grant_port ? p1_write : p0_write;
                  mem_address     <= grant_port ? p1_address : p0_address;
                  mem_data_inputs <= grant_port ? p1_wdata : p0_wdata;
                  state_reg       <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_write_reg || RD_LAT == 0) begin
                  state_reg <= RESP;
               end else begin
                  wait_cnt_reg <= WAIT_INIT;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_reg == 2'd0) begin
                  state_reg <= RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 2'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Per-port read data registers; only that port's own completed read updates them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else if (capture_en) begin
         if (cmd_port_reg) begin
            p1_rdata <= mem_data_outputs;
         end else begin
            p0_rdata <= mem_data_outputs;
         end
      end
   end

   // Decoded outputs follow the state register, so reset clears them without a clock.
   always_comb begin
      mem_write = (state_reg == ISSUE) && cmd_write_reg;
      busy      = (state_reg != IDLE);
      p0_ack    = (state_reg == RESP) && !cmd_port_reg;
      p1_ack    = (state_reg == RESP) && cmd_port_reg;
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a main RD_LAT=1 instance with a
// behavioural DataMemory, plus RD_LAT=0 and RD_LAT=3 instances reading a
// fixed pattern (data = address ^ 0xA5).
module tb_data_memory_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       p0_req, p0_write, p1_req, p1_write;
   logic [7:0] p0_address, p0_wdata, p1_address, p1_wdata;
   logic       p0_ack, p1_ack, mem_write, busy;
   logic [7:0] p0_rdata, p1_rdata, mem_address, mem_data_inputs, mem_data_outputs;

   // Shared port-0 stimulus for the two latency variants
   logic       q_req;
   logic [7:0] q_address;
   logic       l0_ack, l0_ack1, l0_mw, l0_busy;
   logic [7:0] l0_rdata, l0_rdata1, l0_maddr, l0_mdin, l0_mdout;
   logic       l3_ack, l3_ack1, l3_mw, l3_busy;
   logic [7:0] l3_rdata, l3_rdata1, l3_maddr, l3_mdin, l3_mdout;
   logic [7:0] l3_s1, l3_s2, l3_s3;

   int checks = 0;
   int errors = 0;
   int mw_cnt, both_ack;
   logic [7:0] mw_addr, mw_data;
   int t0, t1;

   always #5 clk = ~clk;

   data_memory_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_write(p0_write), .p0_address(p0_address), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_write(p1_write), .p1_address(p1_address), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .mem_address(mem_address), .mem_write(mem_write), .mem_data_inputs(mem_data_inputs),
      .mem_data_outputs(mem_data_outputs), .busy(busy)
   );

   data_memory_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(0)) dut_l0 (
      .clk(clk), .reset(reset),
      .p0_req(q_req), .p0_write(1'b0), .p0_address(q_address), .p0_wdata(8'h00),
      .p0_ack(l0_ack), .p0_rdata(l0_rdata),
      .p1_req(1'b0), .p1_write(1'b0), .p1_address(8'h00), .p1_wdata(8'h00),
      .p1_ack(l0_ack1), .p1_rdata(l0_rdata1),
      .mem_address(l0_maddr), .mem_write(l0_mw), .mem_data_inputs(l0_mdin),
      .mem_data_outputs(l0_mdout), .busy(l0_busy)
   );

   data_memory_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(3)) dut_l3 (
      .clk(clk), .reset(reset),
      .p0_req(q_req), .p0_write(1'b0), .p0_address(q_address), .p0_wdata(8'h00),
      .p0_ack(l3_ack), .p0_rdata(l3_rdata),
      .p1_req(1'b0), .p1_write(1'b0), .p1_address(8'h00), .p1_wdata(8'h00),
      .p1_ack(l3_ack1), .p1_rdata(l3_rdata1),
      .mem_address(l3_maddr), .mem_write(l3_mw), .mem_data_inputs(l3_mdin),
      .mem_data_outputs(l3_mdout), .busy(l3_busy)
   );

   // Main DataMemory model: synchronous write, one-edge registered read
   logic [7:0] mem_model [0:255];
   always @(posedge clk) begin
      if (mem_write) mem_model[mem_address] <= mem_data_inputs;
      mem_data_outputs <= mem_model[mem_address];
   end

   // Zero-latency pattern ROM
   assign l0_mdout = l0_maddr ^ 8'hA5;

   // Three-edge pipelined pattern ROM
   always @(posedge clk) begin
      l3_s1 <= l3_maddr ^ 8'hA5;
      l3_s2 <= l3_s1;
      l3_s3 <= l3_s2;
   end
   assign l3_mdout = l3_s3;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait for the requested ports to ack, dropping each req at its ack; ends in IDLE.
   task automatic wait_acks(input bit w0, input bit w1, input int maxc,
                            output int a0, output int a1);
      a0 = -1;
      a1 = -1;
      mw_cnt = 0;
      both_ack = 0;
      for (int n = 1; n <= maxc; n++) begin
         tick();
         if (mem_write) begin
            mw_cnt++;
            mw_addr = mem_address;
            mw_data = mem_data_inputs;
         end
         if (p0_ack && p1_ack) both_ack = 1;
         if (p0_ack && a0 < 0) begin a0 = n; p0_req = 1'b0; end
         if (p1_ack && a1 < 0) begin a1 = n; p1_req = 1'b0; end
         if ((!w0 || a0 >= 0) && (!w1 || a1 >= 0)) break;
      end
      tick();
   endtask

   int order [6];
   int k, cnt0;
   int lat0, lat3;
   logic [7:0] rd_addrs [2];

   initial begin
      reset = 1'b0;
      p0_req = 0; p0_write = 0; p0_address = 0; p0_wdata = 0;
      p1_req = 0; p1_write = 0; p1_address = 0; p1_wdata = 0;
      q_req = 0; q_address = 0;
      tick();
      tick();

      // Reset state
      check("rst_p0_ack", p0_ack, 0);
      check("rst_p1_ack", p1_ack, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_busy", busy, 0);
      check("rst_p0_rdata", p0_rdata, 0);
      check("rst_p1_rdata", p1_rdata, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_data_inputs", mem_data_inputs, 0);
      reset = 1'b1;
      tick();

      // p0 writes 0x55 to 0x02
      p0_write = 1; p0_address = 8'h02; p0_wdata = 8'h55; p0_req = 1;
      wait_acks(1, 0, 20, t0, t1);
      $display("txn p0 write addr=02 data=55 ack_lat=%0d mw_cycles=%0d", t0, mw_cnt);
      check("wr_lat", t0, 2);
      check("wr_mw_cycles", mw_cnt, 1);
      check("wr_mw_addr", mw_addr, 8'h02);
      check("wr_mw_data", mw_data, 8'h55);

      // p0 reads 0x02
      p0_write = 0; p0_req = 1;
      wait_acks(1, 0, 20, t0, t1);
      $display("txn p0 read addr=02 ack_lat=%0d rdata=%02h", t0, p0_rdata);
      check("rd_lat", t0, 3);
      check("rd_data", p0_rdata, 8'h55);
      check("rd_no_write", mw_cnt, 0);

      // Fresh reset, then simultaneous p0 write / p1 read of 0x0A
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      p0_write = 1; p0_address = 8'h0A; p0_wdata = 8'hCC;
      p1_write = 0; p1_address = 8'h0A;
      p0_req = 1; p1_req = 1;
      wait_acks(1, 1, 30, t0, t1);
      $display("txn tie p0 write/p1 read addr=0A p0_lat=%0d p1_lat=%0d p1_rdata=%02h", t0, t1, p1_rdata);
      check("tie_p0_lat", t0, 2);
      check("tie_p1_lat", t1, 6);
      check("tie_p1_data", p1_rdata, 8'hCC);
      check("tie_no_double_ack", both_ack, 0);

      // Fairness: both reading 0x0A continuously
      p0_write = 0; p0_address = 8'h0A;
      p1_write = 0; p1_address = 8'h0A;
      p0_req = 1; p1_req = 1;
      k = 0;
      cnt0 = 0;
      both_ack = 0;
      for (int n = 0; n < 80 && k < 6; n++) begin
         tick();
         if (p0_ack && p1_ack) both_ack = 1;
         if (p0_ack) begin order[k] = 0; k++; cnt0++; end
         else if (p1_ack) begin order[k] = 1; k++; end
         if (k == 6) begin p0_req = 0; p1_req = 0; end
      end
      p0_req = 0; p1_req = 0;
      tick();
      check("fair_count", k, 6);
      for (int i = 0; i < k; i++) begin
         $display("txn fairness ack #%0d port=%0d", i, order[i]);
         check("fair_order", order[i], i % 2);
      end
      check("fair_p0_total", cnt0, 3);
      check("fair_no_double_ack", both_ack, 0);

      // rdata isolation
      p1_write = 0; p1_address = 8'h02; p1_req = 1;
      wait_acks(0, 1, 20, t0, t1);
      $display("txn p1 read addr=02 ack_lat=%0d rdata=%02h", t1, p1_rdata);
      check("iso_p1_lat", t1, 3);
      check("iso_p1_data", p1_rdata, 8'h55);
      check("iso_p0_keep1", p0_rdata, 8'hCC);
      p0_write = 1; p0_address = 8'h03; p0_wdata = 8'h11; p0_req = 1;
      wait_acks(1, 0, 20, t0, t1);
      $display("txn p0 write addr=03 data=11 ack_lat=%0d", t0);
      check("iso_p0_wr_lat", t0, 2);
      check("iso_p1_keep", p1_rdata, 8'h55);
      check("iso_p0_keep2", p0_rdata, 8'hCC);

      // Asynchronous reset in the middle of a p0 read
      p0_write = 0; p0_address = 8'h02; p0_req = 1;
      tick();
      tick();
      check("mid_busy_before", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      $display("txn async reset during WAIT busy=%0d mem_write=%0d", busy, mem_write);
      check("mid_busy_async", busy, 0);
      check("mid_mw_async", mem_write, 0);
      check("mid_addr_async", mem_address, 0);
      check("mid_ack_async", p0_ack, 0);
      p0_req = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_no_ack", p0_ack, 0);
      end
      reset = 1'b1;
      tick();
      check("mid_idle_after", busy, 0);

      // After release p0 wins the first tie
      p0_write = 1; p0_address = 8'h04; p0_wdata = 8'h77;
      p1_write = 0; p1_address = 8'h04;
      p0_req = 1; p1_req = 1;
      wait_acks(1, 1, 30, t0, t1);
      $display("txn post-reset tie p0_lat=%0d p1_lat=%0d p1_rdata=%02h", t0, t1, p1_rdata);
      check("post_p0_first", t0, 2);
      check("post_p1_lat", t1, 6);
      check("post_p1_data", p1_rdata, 8'h77);

      // RD_LAT = 0 and RD_LAT = 3 instances; req drops at the first ack
      rd_addrs[0] = 8'h3C;
      rd_addrs[1] = 8'hF0;
      for (int r = 0; r < 2; r++) begin
         q_address = rd_addrs[r];
         q_req = 1;
         lat0 = -1;
         lat3 = -1;
         for (int n = 1; n <= 20; n++) begin
            tick();
            if (l0_ack && lat0 < 0) begin lat0 = n; q_req = 0; end
            if (l3_ack && lat3 < 0) begin lat3 = n; q_req = 0; end
            if (lat0 >= 0 && lat3 >= 0) break;
         end
         q_req = 0;
         $display("txn lat builds addr=%02h l0_lat=%0d l0_data=%02h l3_lat=%0d l3_data=%02h",
                  q_address, lat0, l0_rdata, lat3, l3_rdata);
         check("lat0_ack", lat0, 2);
         check("lat3_ack", lat3, 5);
         check("lat0_data", l0_rdata, rd_addrs[r] ^ 8'hA5);
         check("lat3_data", l3_rdata, rd_addrs[r] ^ 8'hA5);
         for (int i = 0; i < 8; i++) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 8-bit DataMemory.
- Port 0 is the CPU load/store unit; port 1 is the I/O/DMA engine.
- Arbitrates round-robin, latches the winner's command, drives the DataMemory address/write/data_inputs pins, waits the configured read latency, captures data_outputs, and returns a one-cycle ack with read data to the winner.
- Exactly one memory access is in flight at any time.

Parameters:
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory data width.
- RD_LAT, 1, clock edges from address presentation to valid mem_data_outputs (legal 0..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_write  in  1  port 0 op: 1 = write, 0 = read.
- p0_address  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_req, p1_write, p1_address, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1.
- mem_address  out  ADDR_WIDTH  to DataMemory address.
- mem_write  out  1  to DataMemory write.
- mem_data_inputs  out  DATA_WIDTH  to DataMemory data_inputs.
- mem_data_outputs  in  DATA_WIDTH  from DataMemory data_outputs.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. When reset is low, all state clears immediately, independent of clk.
- Reset values:
  - p0_ack, p1_ack, mem_write, busy = 0.
  - p0_rdata, p1_rdata, mem_address, mem_data_inputs = 0.
  - State = IDLE; last_grant = 1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port that is not last_grant.
  - On grant: latch winner's write/address/wdata into the cmd registers, update last_grant, go to ISSUE. mem_address and mem_data_inputs load from the cmd at this same edge.
- ISSUE (one cycle):
  - mem_address and mem_data_inputs show the latched cmd. mem_write = cmd write, and this is the only state in which mem_write can be 1.
  - Write: go to RESP.
  - Read with RD_LAT = 0: capture mem_data_outputs at the end of ISSUE, go to RESP.
  - Read with RD_LAT > 0: go to WAIT.
- WAIT:
  - Hold mem_address, with mem_write = 0, for RD_LAT cycles using a 2-bit counter.
  - Capture mem_data_outputs into the winner's rdata at the end of the last WAIT cycle, then go to RESP.
- RESP (one cycle):
  - Winner's ack = 1, the other port's ack = 0. Go to IDLE.
- Latency, from the edge at which req is sampled in IDLE to the ack cycle:
  - Write: 2 cycles.
  - Read: 2 + RD_LAT cycles.
  - Back-to-back minimum: one IDLE cycle between consecutive accesses.
- rdata:
  - Per-port register, updated only by that port's completed read.
  - Writes and other-port accesses leave it unchanged. Valid during and after ack.
- Requesters hold req/write/address/wdata stable until ack.
  - Changes after grant are ignored, because the cmd is latched.
  - A req still high in the IDLE cycle after ack is a new request.
- Alternation: with both reqs continuously high, grants alternate 0, 1, 0, 1.
- Deasserted req: if a requester drops req before its ack, the latched access still completes and ack still pulses.
- Reset mid-operation:
  - Access is abandoned and no ack is issued. mem_write drops to 0 immediately.
  - A write is only guaranteed not to occur if reset asserts before the ISSUE-cycle end edge.
- busy = 1 in ISSUE, WAIT and RESP.

Test Plan:
- Single write then read, RD_LAT = 1:
  - p0 writes 0x55 to 0x02: mem_write high for exactly one cycle with mem_address = 0x02; p0_ack 2 cycles after req.
  - p0 reads 0x02: p0_ack 3 cycles after req, p0_rdata = 0x55.
- Simultaneous requests after reset:
  - p0 writes 0xCC to 0x0A while p1 reads 0x0A: p0 is granted first.
  - p1 then completes with p1_rdata = 0xCC.
- Fairness: both reqs held continuously for 6 accesses → ack order 0, 1, 0, 1, 0, 1 → each port completes 3.
- rdata isolation:
  - p1 reads 0x02 (value 0x55).
  - p0 then writes 0x11 to 0x03 → p1_rdata stays 0x55; p0_rdata unchanged.
- Async reset mid-read:
  - reset goes low during WAIT → without waiting for a clock edge, state returns to IDLE, busy = 0, mem_write = 0, no ack.
  - After release, p0 wins the first tie.
- RD_LAT = 0 and RD_LAT = 3 builds: read acks at 2 and 5 cycles after req, data correct.
